// File: rtl/sonar_pkg.sv
// Shared types and widths for the sonar receive chain.
package sonar_pkg;

    localparam int unsigned SONAR_SAMPLE_W = 16;
    localparam int unsigned SONAR_COUNT_W  = 24;

    typedef enum logic [2:0] {
        IDLE,
        BLANK,
        LISTEN,
        ECHO,
        REPORT
    } echo_state_t;

endpackage

// File: rtl/envelope_avg.sv
// Envelope former: |sample| with saturation of the most negative code, moving
// sum over the last 2**AVG_LOG2 accepted magnitudes, env = sum >> AVG_LOG2.
// env_valid_o is high exactly two cycles after a sample is accepted.
module envelope_avg
    import sonar_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SONAR_SAMPLE_W,
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                valid_i,
    output logic [SAMPLE_W-1:0] env_o,
    output logic                env_valid_o
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = SAMPLE_W + AVG_LOG2;
    localparam logic [SAMPLE_W-1:0] NEG_FULL = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] POS_FULL = {1'b0, {(SAMPLE_W-1){1'b1}}};

    logic [SAMPLE_W-1:0] abs_d;
    logic [SAMPLE_W-1:0] abs_q;
    logic                acc_q;
    logic [SAMPLE_W-1:0] win_q [DEPTH];
    logic [SUM_W-1:0]    sum_d;
    logic [SUM_W-1:0]    sum_q;
    logic                env_valid_q;

    // Magnitude of the incoming sample; the most negative code has no positive twin.
    always_comb begin
        abs_d = sample_i;
        if (sample_i == NEG_FULL) begin
            abs_d = POS_FULL;
        end else if (sample_i[SAMPLE_W-1]) begin
            abs_d = -sample_i;
        end
    end

    // Stage 1: register the magnitude and the acceptance flag.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            abs_q <= '0;
            acc_q <= 1'b0;
        end else if (clear_i) begin
            abs_q <= '0;
            acc_q <= 1'b0;
        end else begin
            acc_q <= valid_i;
            if (valid_i) begin
                abs_q <= abs_d;
            end
        end
    end

    // Running sum: add the newest magnitude, drop the one leaving the window.
    always_comb begin
        sum_d = sum_q + SUM_W'(abs_q) - SUM_W'(win_q[DEPTH-1]);
    end

    // Stage 2: shift the window, update the sum, raise env_valid.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q       <= '0;
            env_valid_q <= 1'b0;
        end else if (clear_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q       <= '0;
            env_valid_q <= 1'b0;
        end else begin
            env_valid_q <= acc_q;
            if (acc_q) begin
                win_q[0] <= abs_q;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    win_q[i] <= win_q[i-1];
                end
                sum_q <= sum_d;
            end
        end
    end

    assign env_o       = SAMPLE_W'(sum_q >> AVG_LOG2);
    assign env_valid_o = env_valid_q;

endmodule

// File: rtl/echo_detector.sv
// Echo detector: envelope, post-burst blanking, hysteresis thresholds and a
// valid/ready time-of-flight result with timeout qualifier.
// Optional feature macro: ECHO_PEAK_EN (peak envelope tracking on echo_peak_out).
module echo_detector
    import sonar_pkg::*;
#(
    parameter int unsigned SAMPLE_W     = SONAR_SAMPLE_W,
    parameter int unsigned COUNT_W      = SONAR_COUNT_W,
    parameter int unsigned AVG_LOG2     = 3,
    parameter int unsigned BLANK_CYCLES = 524288,
    parameter int unsigned LISTEN_LIMIT = 16777215
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                burst_start_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid_in,
    input  logic [SAMPLE_W-1:0] thresh_hi_in,
    input  logic [SAMPLE_W-1:0] thresh_lo_in,
    output logic                echo_valid_out,
    input  logic                echo_ready_in,
    output logic [COUNT_W-1:0]  tof_cycles_out,
    output logic [SAMPLE_W-1:0] echo_peak_out,
    output logic                timeout_out,
    output logic                busy_out
);

    localparam logic [COUNT_W-1:0] BLANK_LAST = COUNT_W'(BLANK_CYCLES - 1);
    localparam logic [COUNT_W-1:0] LIMIT      = COUNT_W'(LISTEN_LIMIT);

    echo_state_t         state_q, state_d;
    logic [COUNT_W-1:0]  cnt_q;
    logic [SAMPLE_W-1:0] hi_q, lo_q, lo_eff;
    logic [COUNT_W-1:0]  tof_q, tof_d;
    logic                timeout_q, timeout_d;
    logic [SAMPLE_W-1:0] env;
    logic                env_valid;
`ifdef ECHO_PEAK_EN
    logic [SAMPLE_W-1:0] peak_q, peak_d;
`endif

    envelope_avg #(
        .SAMPLE_W (SAMPLE_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_env (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .clear_i     (burst_start_in),
        .sample_i    (sample_in),
        .valid_i     (sample_valid_in),
        .env_o       (env),
        .env_valid_o (env_valid)
    );

    // Time since burst: restarts on burst_start_in, saturates at all ones.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (burst_start_in) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Thresholds are latched per burst so mid-burst changes cannot glitch detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (burst_start_in) begin
            hi_q <= thresh_hi_in;
            lo_q <= thresh_lo_in;
        end
    end

    // Release threshold never above the detection threshold.
    always_comb begin
        lo_eff = (lo_q < hi_q) ? lo_q : hi_q;
    end

    // Next state and result capture.
    always_comb begin
        state_d   = state_q;
        tof_d     = tof_q;
        timeout_d = timeout_q;
`ifdef ECHO_PEAK_EN
        peak_d    = peak_q;
`endif
        if (burst_start_in) begin
            state_d = BLANK;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = LISTEN;
                    end
                end
                LISTEN: begin
                    if (env_valid && (env > hi_q)) begin
                        state_d   = ECHO;
                        tof_d     = cnt_q;
                        timeout_d = 1'b0;
`ifdef ECHO_PEAK_EN
                        peak_d    = env;
`endif
                    end else if (cnt_q >= LIMIT) begin
                        state_d   = REPORT;
                        tof_d     = '1;
                        timeout_d = 1'b1;
`ifdef ECHO_PEAK_EN
                        peak_d    = '0;
`endif
                    end
                end
                ECHO: begin
`ifdef ECHO_PEAK_EN
                    if (env_valid && (env > peak_q)) begin
                        peak_d = env;
                    end
`endif
                    // >= so an echo entered exactly at the limit still terminates.
                    if ((env_valid && (env < lo_eff)) || (cnt_q >= LIMIT)) begin
                        state_d   = REPORT;
                        timeout_d = 1'b0;
                    end
                end
                REPORT: begin
                    if (echo_ready_in) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tof_q     <= '0;
            timeout_q <= 1'b0;
`ifdef ECHO_PEAK_EN
            peak_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tof_q     <= tof_d;
            timeout_q <= timeout_d;
`ifdef ECHO_PEAK_EN
            peak_q    <= peak_d;
`endif
        end
    end

    assign echo_valid_out = (state_q == REPORT);
    assign busy_out       = (state_q == BLANK) || (state_q == LISTEN) || (state_q == ECHO);
    assign tof_cycles_out = tof_q;
    assign timeout_out    = timeout_q;
`ifdef ECHO_PEAK_EN
    assign echo_peak_out  = peak_q;
`else
    assign echo_peak_out  = '0;
`endif

endmodule

// File: tb/tb_echo_detector.sv
// Bench for echo_detector: behavioural model plus directed and random bursts.
module tb_echo_detector;

    localparam int BLANK = 64;
    localparam int LIMIT = 1024;
    localparam int ALL1  = 24'hFFFFFF;
`ifdef ECHO_PEAK_EN
    localparam int PEAK_ON = 1;
`else
    localparam int PEAK_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        burst;
    logic [15:0] sample;
    logic        svalid;
    logic [15:0] hi, lo;
    logic        ready;
    logic        valid_o;
    logic [23:0] tof_o;
    logic [15:0] peak_o;
    logic        to_o;
    logic        busy_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    echo_detector #(
        .SAMPLE_W     (16),
        .COUNT_W      (24),
        .AVG_LOG2     (3),
        .BLANK_CYCLES (BLANK),
        .LISTEN_LIMIT (LIMIT)
    ) dut (
        .clk_in          (clk),
        .rst_n           (rst_n),
        .burst_start_in  (burst),
        .sample_in       (sample),
        .sample_valid_in (svalid),
        .thresh_hi_in    (hi),
        .thresh_lo_in    (lo),
        .echo_valid_out  (valid_o),
        .echo_ready_in   (ready),
        .tof_cycles_out  (tof_o),
        .echo_peak_out   (peak_o),
        .timeout_out     (to_o),
        .busy_out        (busy_o)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {longint due; int env;} ev_t;
    ev_t    evq[$];
    longint cyc = 0;
    int     win[8];
    int     wptr;
    int     m_cnt, m_hi, m_lo, m_tof, m_peak;
    bit     m_active, m_echo, m_rep, m_to;

    always @(posedge clk or negedge rst_n) begin : model
        int  a, sum, sv, ev_e;
        bit  ev_v;
        if (!rst_n) begin
            evq.delete();
            foreach (win[i]) win[i] = 0;
            wptr = 0; m_cnt = 0; m_hi = 0; m_lo = 0; m_tof = 0; m_peak = 0;
            m_active = 0; m_echo = 0; m_rep = 0; m_to = 0;
        end else begin
            ev_v = 0; ev_e = 0;
            if (evq.size() > 0 && evq[0].due == cyc) begin
                ev_v = 1; ev_e = evq[0].env; void'(evq.pop_front());
            end
            if (burst) begin
                evq.delete();
                foreach (win[i]) win[i] = 0;
                m_cnt = 0; m_hi = int'(hi); m_lo = int'(lo);
                m_active = 1; m_echo = 0; m_rep = 0;
            end else begin
                if (svalid) begin
                    sv = $signed(sample);
                    a = (sv == -32768) ? 32767 : ((sv < 0) ? -sv : sv);
                    win[wptr] = a; wptr = (wptr + 1) % 8;
                    sum = 0;
                    foreach (win[i]) sum += win[i];
                    evq.push_back('{cyc + 2, sum / 8});
                end
                if (m_rep) begin
                    if (ready) m_rep = 0;
                end else if (m_echo) begin
                    if (ev_v && ev_e > m_peak) m_peak = ev_e;
                    if ((ev_v && ev_e < ((m_lo < m_hi) ? m_lo : m_hi)) || m_cnt >= LIMIT) begin
                        m_rep = 1; m_echo = 0; m_active = 0; m_to = 0;
                    end
                end else if (m_active && m_cnt >= BLANK) begin
                    if (ev_v && ev_e > m_hi) begin
                        m_echo = 1; m_tof = m_cnt; m_peak = ev_e; m_to = 0;
                    end else if (m_cnt >= LIMIT) begin
                        m_rep = 1; m_active = 0; m_to = 1; m_tof = ALL1; m_peak = 0;
                    end
                end
                if (m_cnt < ALL1) m_cnt++;
            end
            cyc++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", valid_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_tof", tof_o, 0);
            chk("rst_peak", peak_o, 0);
            chk("rst_timeout", to_o, 0);
        end else begin
            chk("valid", valid_o, m_rep);
            chk("busy", busy_o, m_active || m_echo);
            if (m_rep) begin
                chk("tof", tof_o, m_tof);
                chk("peak", peak_o, PEAK_ON ? m_peak : 0);
                chk("timeout", to_o, m_to);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_burst(input int h, input int l);
        burst = 1; hi = 16'(h); lo = 16'(l);
        step();
        burst = 0;
    endtask

    task automatic wait_cnt(input int n);
        int g = 0;
        while (m_cnt != n && g < 3000) begin step(); g++; end
        if (m_cnt != n) begin
            miscompares++;
            $display("FAIL wait_cnt: counter never reached %0d", n);
        end
    endtask

    // Returns at the negedge of the first cycle with echo_valid_out high.
    task automatic wait_valid(input int maxc, output int n);
        bit done = 0;
        n = 0;
        while (!done) begin
            @(negedge clk);
            if (valid_o) done = 1;
            else if (n >= maxc) begin
                miscompares++;
                $display("FAIL wait_valid: no result within %0d cycles", maxc);
                done = 1;
            end else begin
                @(posedge clk); #1; n++;
            end
        end
    endtask

    task automatic accept(input string nm);
        ready = 1;
        step();
        ready = 0;
        @(negedge clk);
        chk({nm, "_valid_drop"}, valid_o, 0);
        chk({nm, "_busy_idle"}, busy_o, 0);
        step();
    endtask

    initial begin : watchdog
        #3000000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : main
        int n, s0, w, amp, ampl, v;
        bit loud;
        rst_n = 0; burst = 0; sample = '0; svalid = 0; hi = '0; lo = '0; ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1;
        step();

        // 1: reset mid-LISTEN
        do_burst(500, 200);
        wait_cnt(100);
        @(negedge clk);
        chk("t1_busy_listen", busy_o, 1);
        @(posedge clk); #3 rst_n = 0;
        #1;
        chk("t1_async_valid", valid_o, 0);
        chk("t1_async_busy", busy_o, 0);
        chk("t1_async_timeout", to_o, 0);
        @(posedge clk); #3 rst_n = 1;
        step();
        @(negedge clk);
        chk("t1_idle_busy", busy_o, 0);
        chk("t1_idle_valid", valid_o, 0);
        step();

        // 2: echo at 206, peak 1000, released by silence
        do_burst(500, 200);
        wait_cnt(200);
        svalid = 1; sample = 16'd1000;
        wait_cnt(300);
        sample = 16'd0;
        wait_valid(400, n);
        chk("t2_tof", tof_o, 206);
        chk("t2_peak", peak_o, PEAK_ON ? 1000 : 0);
        chk("t2_timeout", to_o, 0);
        svalid = 0;
        accept("t2");

        // 3+4: loud only in blanking -> timeout; result held while not ready
        do_burst(500, 200);
        svalid = 1; sample = 16'd30000;
        wait_cnt(51);
        sample = 16'd0;
        wait_cnt(60);
        svalid = 0;
        wait_valid(1200, n);
        chk("t3_tof", tof_o, ALL1);
        chk("t3_peak", peak_o, 0);
        chk("t3_timeout", to_o, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            chk("t4_hold_valid", valid_o, 1);
            chk("t4_hold_tof", tof_o, ALL1);
            chk("t4_hold_timeout", to_o, 1);
        end
        accept("t4");

        // 5: burst during ECHO restarts the listen window
        do_burst(500, 200);
        wait_cnt(100);
        svalid = 1; sample = 16'd2000;
        wait_cnt(120);
        @(negedge clk);
        chk("t5_busy_echo", busy_o, 1);
        step();
        svalid = 0;
        do_burst(500, 200);
        wait_valid(1500, n);
        chk("t5_burst_to_report", n, LIMIT + 1);
        chk("t5_timeout", to_o, 1);
        accept("t5");

        // 6: most negative sample, lo above hi
        do_burst(30000, 40000);
        wait_cnt(70);
        svalid = 1; sample = 16'h8000;
        wait_cnt(200);
        sample = 16'd0;
        wait_valid(400, n);
        chk("t6_report_cnt", m_cnt, 203);
        chk("t6_tof", tof_o, 79);
        chk("t6_peak", peak_o, PEAK_ON ? 32767 : 0);
        chk("t6_timeout", to_o, 0);
        svalid = 0;
        accept("t6");

        // random bursts
        for (int b = 0; b < 8; b++) begin
            do_burst($urandom_range(300, 8000), $urandom_range(0, 8000));
            s0  = $urandom_range(64, 900);
            w   = $urandom_range(5, 200);
            amp = $urandom_range(1000, 32767);
            for (int c = 0; c < 1200; c++) begin
                svalid = ($urandom_range(0, 3) != 0);
                loud = (m_cnt >= s0 && m_cnt < s0 + w) || (m_cnt < 40);
                if ($urandom_range(0, 60) == 0) sample = 16'h8000;
                else begin
                    ampl = loud ? amp : 200;
                    v = int'($urandom_range(0, 2 * ampl)) - ampl;
                    sample = 16'(v);
                end
                ready = ($urandom_range(0, 2) == 0);
                burst = ($urandom_range(0, 1499) == 0);
                hi = 16'($urandom_range(300, 8000));
                lo = 16'($urandom_range(0, 8000));
                step();
            end
            burst = 0; svalid = 0;
            ready = 1;
            repeat (3) step();
            ready = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
